// File: rtl/range_tracker_stats_if.sv
// Sample/strobe/result bundle between the pin sampler and the range tracker.
// The master drives samples and strobes; the slave returns the selected statistic and status.
interface range_tracker_stats_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] data_in;
    logic             sample;
    logic             go;
    logic             finish;
    logic [1:0]       mode;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             error;
    logic             busy;

    modport master (
        output data_in, sample, go, finish, mode,
        input  result, result_valid, error, busy
    );

    modport slave (
        input  data_in, sample, go, finish, mode,
        output result, result_valid, error, busy
    );
endinterface

// File: rtl/range_tracker_stats.sv
// Session-based min/max/count tracker. The result is a mode-selected statistic,
// presented only while a finished session is held in DONE.
module range_tracker_stats #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    range_tracker_stats_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] RES_MAX = CNT_W'({WIDTH{1'b1}});

    state_t           state_q, state_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_d;

    // Running update used both for ordinary samples and the sample on the finish cycle.
    logic [WIDTH-1:0] min_upd, max_upd;
    logic [CNT_W-1:0] cnt_upd;
    assign min_upd = (bus.data_in < min_q) ? bus.data_in : min_q;
    assign max_upd = (bus.data_in > max_q) ? bus.data_in : max_q;
    assign cnt_upd = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            min_q   <= '0;
            max_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_TRACK: begin
                if (bus.sample && !(bus.go && !bus.finish)) begin
                    min_d = min_upd;
                    max_d = max_upd;
                    cnt_d = cnt_upd;
                end
                if (bus.finish) begin
                    state_d = S_DONE;
                end else if (bus.go) begin
                    min_d = bus.data_in;
                    max_d = bus.data_in;
                    cnt_d = CNT_W'(1);
                end
            end
            default: begin
                if (bus.go) begin
                    state_d = S_TRACK;
                    min_d   = bus.data_in;
                    max_d   = bus.data_in;
                    cnt_d   = CNT_W'(1);
                end else if (bus.finish) begin
                    state_d = S_ERROR;
                end
            end
        endcase
    end

    // min_q <= max_q always holds, so the range subtraction cannot wrap.
    always_comb begin
        result_d = '0;
        if (state_q == S_DONE) begin
            case (bus.mode)
                2'd0:    result_d = max_q - min_q;
                2'd1:    result_d = min_q;
                2'd2:    result_d = max_q;
                default: result_d = (cnt_q > RES_MAX) ? {WIDTH{1'b1}} : cnt_q[WIDTH-1:0];
            endcase
        end
    end

    assign bus.result       = result_d;
    assign bus.result_valid = (state_q == S_DONE);
    assign bus.error        = (state_q == S_ERROR);
    assign bus.busy         = (state_q == S_TRACK);
endmodule

// File: tb/tb_range_tracker_stats.sv
// Directed bench for range_tracker_stats: stimulus queues expected outputs,
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_range_tracker_stats;
    logic clock;
    logic reset;

    range_tracker_stats_if #(.WIDTH(4)) bus ();

    range_tracker_stats #(.WIDTH(4), .CNT_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    string      name_q[$];
    logic [6:0] exp_q[$];

    // Each queued entry applies to the cycle in which it was pushed.
    always @(negedge clock) begin
        while (exp_q.size() > 0) begin
            automatic string      nm  = name_q.pop_front();
            automatic logic [6:0] exp = exp_q.pop_front();
            automatic logic [6:0] act = {bus.result, bus.result_valid, bus.error, bus.busy};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL %s: got result=%0d valid=%b error=%b busy=%b, want result=%0d valid=%b error=%b busy=%b",
                         nm, act[6:3], act[2], act[1], act[0], exp[6:3], exp[2], exp[1], exp[0]);
            end else begin
                $display("ok   %s: result=%0d valid=%b error=%b busy=%b",
                         nm, act[6:3], act[2], act[1], act[0]);
            end
        end
    end

    task automatic drive(input logic g, input logic f, input logic s,
                         input logic [3:0] d, input logic [1:0] m);
        bus.go      = g;
        bus.finish  = f;
        bus.sample  = s;
        bus.data_in = d;
        bus.mode    = m;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [3:0] res,
                              input logic v, input logic e, input logic b);
        name_q.push_back(nm);
        exp_q.push_back({res, v, e, b});
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 4'd0, 2'd0);
        tick();
        tick();
        reset = 1'b0;
        expect_out("reset_idle", 4'd0, 0, 0, 0);
        tick();

        // Basic session: 5, 9, 2, then 12 on the finish cycle.
        drive(1, 0, 0, 4'd5, 2'd0);  tick();
        drive(0, 0, 1, 4'd9, 2'd0);
        expect_out("basic_busy", 4'd0, 0, 0, 1);
        tick();
        drive(0, 0, 1, 4'd2, 2'd0);  tick();
        drive(0, 1, 1, 4'd12, 2'd0); tick();
        drive(0, 0, 0, 4'd0, 2'd0); expect_out("basic_range", 4'd10, 1, 0, 0); tick();
        drive(0, 0, 0, 4'd0, 2'd1); expect_out("basic_min",   4'd2,  1, 0, 0); tick();
        drive(0, 0, 0, 4'd0, 2'd2); expect_out("basic_max",   4'd12, 1, 0, 0); tick();
        drive(0, 0, 0, 4'd0, 2'd3); expect_out("basic_count", 4'd4,  1, 0, 0); tick();

        // Back to IDLE through an asynchronous reset, then the error path.
        reset = 1'b1;
        expect_out("reset_from_done", 4'd0, 0, 0, 0);
        tick();
        reset = 1'b0;
        drive(0, 1, 0, 4'd0, 2'd3); tick();
        drive(0, 0, 0, 4'd0, 2'd3); expect_out("err_flag", 4'd0, 0, 1, 0); tick();
        drive(1, 0, 0, 4'd7, 2'd3); tick();
        drive(0, 0, 0, 4'd0, 2'd3); expect_out("err_go_busy", 4'd0, 0, 0, 1);
        drive(0, 1, 0, 4'd0, 2'd3); tick();
        drive(0, 0, 0, 4'd0, 2'd0); expect_out("err_range", 4'd0, 1, 0, 0); tick();
        drive(0, 0, 0, 4'd0, 2'd3); expect_out("err_count", 4'd1, 1, 0, 0); tick();

        // Priority: go+finish in DONE restarts; go+finish in TRACK finishes.
        drive(1, 1, 0, 4'd3, 2'd0); tick();
        drive(0, 0, 1, 4'd10, 2'd0); expect_out("prio_done_restart", 4'd0, 0, 0, 1); tick();
        drive(1, 1, 0, 4'd15, 2'd0); tick();
        drive(0, 0, 0, 4'd0, 2'd0); expect_out("prio_track_range", 4'd7,  1, 0, 0); tick();
        drive(0, 0, 0, 4'd0, 2'd2); expect_out("prio_track_max",   4'd10, 1, 0, 0); tick();
        drive(0, 0, 0, 4'd0, 2'd3); expect_out("prio_track_count", 4'd2,  1, 0, 0); tick();

        // Saturation with sample=0 cycles carrying out-of-range data first.
        drive(1, 0, 0, 4'd6, 2'd0);  tick();
        drive(0, 0, 0, 4'd0, 2'd0);  tick();
        drive(0, 0, 0, 4'd15, 2'd0); tick();
        for (int i = 0; i < 300; i++) begin
            drive(0, 0, 1, 4'(5 + (i % 3)), 2'd0);
            tick();
        end
        drive(0, 1, 0, 4'd0, 2'd0); tick();
        drive(0, 0, 0, 4'd0, 2'd0); expect_out("sat_range", 4'd2,  1, 0, 0); tick();
        drive(0, 0, 0, 4'd0, 2'd1); expect_out("sat_min",   4'd5,  1, 0, 0); tick();
        drive(0, 0, 0, 4'd0, 2'd2); expect_out("sat_max",   4'd7,  1, 0, 0); tick();
        drive(0, 0, 0, 4'd0, 2'd3); expect_out("sat_count", 4'd15, 1, 0, 0); tick();
        checks++;
        if (dut.cnt_q !== 8'd255) begin
            errors++;
            $display("FAIL sat_cnt_q: got %0d, want 255", dut.cnt_q);
        end else begin
            $display("ok   sat_cnt_q: %0d", dut.cnt_q);
        end

        // Reset mid-session, then a one-sample session.
        drive(1, 0, 0, 4'd3, 2'd0);  tick();
        drive(0, 0, 1, 4'd14, 2'd0); tick();
        drive(0, 0, 0, 4'd0, 2'd0);
        reset = 1'b1;
        expect_out("rst_mid", 4'd0, 0, 0, 0);
        tick();
        reset = 1'b0;
        drive(1, 0, 0, 4'd8, 2'd0); tick();
        drive(0, 1, 0, 4'd0, 2'd0); tick();
        drive(0, 0, 0, 4'd0, 2'd0); expect_out("rst_new_range", 4'd0, 1, 0, 0); tick();
        drive(0, 0, 0, 4'd0, 2'd1); expect_out("rst_new_min",   4'd8, 1, 0, 0); tick();

        begin
            int waited = 0;
            while (exp_q.size() > 0 && waited < 10) begin
                @(negedge clock);
                waited++;
            end
            if (exp_q.size() > 0) begin
                errors++;
                $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
            end
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
